// File: rtl/scr1_fpu_pkg.sv
// Shared FP types for the FP write-back path: register address, flags and the
// buffered write-back entry.
package scr1_fpu_pkg;

  localparam int unsigned SCR1_XLEN = 32;
  localparam int unsigned FPRF_AW   = 5;

  typedef logic [4:0]         fp_fflags_t;
  typedef logic [FPRF_AW-1:0] fp_addr_t;

  typedef struct packed {
    fp_addr_t               rd;
    logic [SCR1_XLEN-1:0]   data;
    fp_fflags_t             fflags;
  } fp_wb_entry_t;

endpackage

// File: rtl/scr1_pipe_fpwb_fifo.sv
// Synchronous FIFO of FP write-back entries; full/empty come from a registered
// occupancy count so they never depend combinationally on push or pop.
module scr1_pipe_fpwb_fifo
  import scr1_fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fp_wb_entry_t din,
  input  logic         pop,
  output fp_wb_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fp_wb_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/scr1_pipe_fpwb.sv
// FP write-back stage: arbitrates FLW load data over buffered FPU results onto the
// single FPRF write port and tracks per-register busy bits for decode hazards.
module scr1_pipe_fpwb
  import scr1_fpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DATA_W     = SCR1_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_vld_i,
  input  logic [4:0]        iss_rd_i,
  output logic              iss_rdy_o,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [4:0]        rs3_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              rs3_busy_o,
  input  logic              fpu_vld_i,
  output logic              fpu_rdy_o,
  input  logic [4:0]        fpu_rd_i,
  input  logic [DATA_W-1:0] fpu_data_i,
  input  logic [4:0]        fpu_fflags_i,
  input  logic              lsu_vld_i,
  input  logic [4:0]        lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              w_req_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              fflags_vld_o,
  output logic [4:0]        fflags_o
);

  fp_wb_entry_t      fpu_entry;
  fp_wb_entry_t      head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fpu_xfer;

  logic              w_req_q;
  logic [4:0]        rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              fflags_vld_q;
  logic [4:0]        fflags_q;
  logic [31:0]       busy_q;
  logic [31:0]       busy_d;

  // The buffered entry carries SCR1_XLEN data bits; DATA_W is expected to match.
  assign fpu_entry = '{rd: fpu_rd_i, data: fpu_data_i, fflags: fpu_fflags_i};

  assign fpu_rdy_o = !fifo_full;
  assign fpu_xfer  = fpu_vld_i & fpu_rdy_o;
  assign fifo_pop  = !lsu_vld_i & !fifo_empty;
  // Bypass only when nothing older is queued and the port is free this cycle.
  assign fifo_push = fpu_xfer & (lsu_vld_i | !fifo_empty);

  scr1_pipe_fpwb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fpu_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      w_req_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      fflags_vld_q <= 1'b0;
      fflags_q     <= '0;
    end else if (lsu_vld_i) begin
      w_req_q      <= 1'b1;
      rd_addr_q    <= lsu_rd_i;
      rd_data_q    <= lsu_data_i;
      fflags_vld_q <= 1'b0;
      fflags_q     <= '0;
    end else if (!fifo_empty) begin
      w_req_q      <= 1'b1;
      rd_addr_q    <= head.rd;
      rd_data_q    <= head.data;
      fflags_vld_q <= 1'b1;
      fflags_q     <= head.fflags;
    end else if (fpu_xfer) begin
      w_req_q      <= 1'b1;
      rd_addr_q    <= fpu_rd_i;
      rd_data_q    <= fpu_data_i;
      fflags_vld_q <= 1'b1;
      fflags_q     <= fpu_fflags_i;
    end else begin
      w_req_q      <= 1'b0;
      fflags_vld_q <= 1'b0;
    end
  end

  assign w_req_o      = w_req_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;
  assign fflags_vld_o = fflags_vld_q;
  assign fflags_o     = fflags_q;

  assign iss_rdy_o  = !busy_q[iss_rd_i];
  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];
  assign rs3_busy_o = busy_q[rs3_addr_i];

  // Set is applied after clear so a same-edge re-issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (w_req_q) busy_d[rd_addr_q] = 1'b0;
    if (iss_vld_i && iss_rdy_o) busy_d[iss_rd_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && w_req_q) begin
      assert (busy_q[rd_addr_q])
      else $warning("fpwb: write-back to non-busy f%0d", rd_addr_q);
    end
  end
`endif

endmodule
